// File: rtl/serial_2wire_arbiter_pkg.sv
// serial_arb_pkg: arbiter state type and round-robin pick helper
package serial_arb_pkg;
  typedef enum logic [1:0] {Idle, Grant, Active, Release} t_arb_state;
  localparam int MAX_REQ = 32;
  typedef struct packed {
    logic       found;
    logic [4:0] index;
  } t_rr_pick;
  function automatic t_rr_pick rr_pick(input logic [MAX_REQ-1:0] enables, input int num, input int last);
    int idx;
    rr_pick = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      idx = last + k;
      idx = idx >= num ? idx - num : idx;
      if (k <= num && enables[5'(idx)]) rr_pick = '{found: 1'b1, index: 5'(idx)};
    end
  endfunction
endpackage

// File: rtl/serial_2wire_arbiter_if.sv
// serial_2wire_arbiter_if: requester-side and serial-master-side signals of the arbiter
interface serial_2wire_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int BITS      = 8,
  parameter int ADDR_BITS = 8,
  parameter int REQ_BITS  = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                in_req_enable;
  logic [NUM_REQ-1:0]                in_req_write;
  logic [NUM_REQ-1:0][ADDR_BITS-1:0] in_req_addr_write;
  logic [NUM_REQ-1:0][ADDR_BITS-1:0] in_req_addr_read;
  logic [NUM_REQ-1:0][BITS-1:0]      in_req_data;
  logic [BITS-1:0]                   out_req_data;
  logic [NUM_REQ-1:0]                out_req_next_word;
  logic [NUM_REQ-1:0]                out_req_ready;
  logic [NUM_REQ-1:0]                out_req_error;
  logic                              out_grant_valid;
  logic [REQ_BITS-1:0]               out_grant;
  logic                              out_ser_enable;
  logic                              out_ser_write;
  logic [ADDR_BITS-1:0]              out_ser_addr_write;
  logic [ADDR_BITS-1:0]              out_ser_addr_read;
  logic [BITS-1:0]                   out_ser_data;
  logic [BITS-1:0]                   in_ser_data;
  logic                              in_ser_ready;
  logic                              in_ser_next_word;
  logic                              in_ser_error;
  modport slave (
    input  in_req_enable, in_req_write, in_req_addr_write, in_req_addr_read, in_req_data,
    input  in_ser_data, in_ser_ready, in_ser_next_word, in_ser_error,
    output out_req_data, out_req_next_word, out_req_ready, out_req_error,
    output out_grant_valid, out_grant,
    output out_ser_enable, out_ser_write, out_ser_addr_write, out_ser_addr_read, out_ser_data
  );
  modport master (
    output in_req_enable, in_req_write, in_req_addr_write, in_req_addr_read, in_req_data,
    output in_ser_data, in_ser_ready, in_ser_next_word, in_ser_error,
    input  out_req_data, out_req_next_word, out_req_ready, out_req_error,
    input  out_grant_valid, out_grant,
    input  out_ser_enable, out_ser_write, out_ser_addr_write, out_ser_addr_read, out_ser_data
  );
endinterface

// File: rtl/serial_2wire_arbiter.sv
// serial_2wire_arbiter: round-robin sharing of one serial_2wire master between NUM_REQ clients
module serial_2wire_arbiter
  import serial_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int BITS         = 8,
  parameter int ADDR_BITS    = 8,
  parameter int HOLD_TIMEOUT = 0,
  parameter int REQ_BITS     = $clog2(NUM_REQ)
) (
  input logic                   in_clk,
  input logic                   in_rst,
  serial_2wire_arbiter_if.slave bus
);
  t_arb_state          state, state_nx;
  logic [REQ_BITS-1:0] grant, rr_last;
  logic                grant_valid, live, req_en, timeout;
  logic [31:0]         hold_ctr;
  logic [MAX_REQ-1:0]  en_w;
  t_rr_pick            pick;
  assign en_w    = MAX_REQ'(bus.in_req_enable);
  assign pick    = rr_pick(en_w, NUM_REQ, int'(rr_last));
  assign req_en  = bus.in_req_enable[grant];
  assign timeout = state == Active && HOLD_TIMEOUT != 0 && hold_ctr == 32'(HOLD_TIMEOUT - 1);
  // live keeps every ready low until the first clock after reset
  always_ff @(posedge in_clk or negedge in_rst)
    if (!in_rst) begin
      state       <= Idle;
      grant       <= '0;
      grant_valid <= 1'b0;
      rr_last     <= REQ_BITS'(NUM_REQ - 1);
      hold_ctr    <= '0;
      live        <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
      if (state == Idle && state_nx == Grant) begin
        grant       <= REQ_BITS'(pick.index);
        grant_valid <= 1'b1;
      end
      if (state == Active) hold_ctr <= hold_ctr + 32'd1;
      if (state == Release && state_nx == Idle) begin
        rr_last     <= grant;
        grant_valid <= 1'b0;
        hold_ctr    <= '0;
      end
    end
  always_comb
    state_nx = state == Idle   ? ((pick.found && bus.in_ser_ready) ? Grant : Idle) :
               state == Grant  ? Active :
               state == Active ? ((!req_en || timeout) ? Release : Active) :
                                 (bus.in_ser_ready ? Idle : Release);
  always_comb begin
    bus.out_grant_valid    = grant_valid;
    bus.out_grant          = grant;
    bus.out_ser_enable     = state == Active && req_en;
    bus.out_ser_write      = grant_valid && bus.in_req_write[grant];
    bus.out_ser_addr_write = grant_valid ? bus.in_req_addr_write[grant] : '0;
    bus.out_ser_addr_read  = grant_valid ? bus.in_req_addr_read[grant] : '0;
    bus.out_ser_data       = grant_valid ? bus.in_req_data[grant] : '0;
    bus.out_req_data       = bus.in_ser_data;
    bus.out_req_next_word  = '0;
    bus.out_req_error      = '0;
    bus.out_req_ready      = '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.out_req_ready[i] = live && bus.in_ser_ready && (state == Idle || (grant_valid && grant == REQ_BITS'(i)));
    if (grant_valid) begin
      bus.out_req_next_word[grant] = bus.in_ser_next_word;
      bus.out_req_error[grant]     = bus.in_ser_error || timeout;
    end
  end
endmodule

// File: tb/tb_serial_2wire_arbiter.sv
// tb_serial_2wire_arbiter: directed/randomized bench with a round-robin reference model
module tb_serial_2wire_arbiter;
  localparam int NUM_REQ = 2, BITS = 8, ADDR_BITS = 8, HOLD = 16;
  logic in_clk = 1'b0, in_rst = 1'b0;
  int   n_asserts = 0, n_fail = 0, last = NUM_REQ - 1, g;
  serial_2wire_arbiter_if #(.NUM_REQ(NUM_REQ), .BITS(BITS), .ADDR_BITS(ADDR_BITS)) bus ();
  serial_2wire_arbiter #(.NUM_REQ(NUM_REQ), .BITS(BITS), .ADDR_BITS(ADDR_BITS), .HOLD_TIMEOUT(HOLD)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .bus(bus)
  );
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  function automatic int rr_ref(input logic [NUM_REQ-1:0] en, input int l);
    for (int k = 1; k <= NUM_REQ; k++)
      if (en[(l + k) % NUM_REQ]) return (l + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic randomize_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.in_req_write[i]      = 1'($urandom);
      bus.in_req_addr_write[i] = ADDR_BITS'($urandom);
      bus.in_req_addr_read[i]  = ADDR_BITS'($urandom);
      bus.in_req_data[i]       = BITS'($urandom);
    end
  endtask

  task automatic transaction(input logic [NUM_REQ-1:0] en);
    int e;
    logic [BITS-1:0] rx;
    randomize_reqs();
    bus.in_req_enable = en;
    bus.in_ser_ready  = 1'b1;
    e = rr_ref(en, last);
    step();
    check("grant_valid", bus.out_grant_valid, 1);
    check("grant", bus.out_grant, e);
    check("ser_enable_in_grant", bus.out_ser_enable, 0);
    step();
    check("ser_enable_active", bus.out_ser_enable, 1);
    check("ser_write", bus.out_ser_write, bus.in_req_write[e]);
    check("ser_addr_write", bus.out_ser_addr_write, bus.in_req_addr_write[e]);
    check("ser_addr_read", bus.out_ser_addr_read, bus.in_req_addr_read[e]);
    check("ser_data", bus.out_ser_data, bus.in_req_data[e]);
    rx = BITS'($urandom);
    bus.in_ser_ready = 1'b0;
    bus.in_ser_data  = rx;
    bus.in_ser_next_word = 1'b1;
    #1;
    check("req_data", bus.out_req_data, rx);
    check("ready_busy", bus.out_req_ready, 0);
    check("next_word_route", bus.out_req_next_word, 1 << e);
    bus.in_ser_next_word = 1'b0;
    bus.in_ser_error     = 1'b1;
    #1;
    check("error_route", bus.out_req_error, 1 << e);
    bus.in_ser_error = 1'b0;
    step();
    check("grant_hold_on_error", bus.out_grant_valid, 1);
    bus.in_req_enable[e] = 1'b0;
    #1;
    check("ser_enable_drop", bus.out_ser_enable, 0);
    step();
    check("release_valid", bus.out_grant_valid, 1);
    step();
    check("release_wait_valid", bus.out_grant_valid, 1);
    check("release_wait_ready", bus.out_req_ready, 0);
    bus.in_ser_ready = 1'b1;
    #1;
    check("release_ready", bus.out_req_ready, 1 << e);
    step();
    check("idle_valid", bus.out_grant_valid, 0);
    check("idle_ready", bus.out_req_ready, {NUM_REQ{1'b1}});
    last = e;
  endtask

  initial begin
    bus.in_req_enable    = '0;
    bus.in_ser_data      = '0;
    bus.in_ser_ready     = 1'b1;
    bus.in_ser_next_word = 1'b0;
    bus.in_ser_error     = 1'b0;
    randomize_reqs();
    #2;
    check("rst_ready", bus.out_req_ready, 0);
    check("rst_grant_valid", bus.out_grant_valid, 0);
    check("rst_grant", bus.out_grant, 0);
    check("rst_ser_enable", bus.out_ser_enable, 0);
    check("rst_ser_addr_write", bus.out_ser_addr_write, 0);
    check("rst_ser_data", bus.out_ser_data, 0);
    #5 in_rst = 1'b1;
    #1;
    check("ready_before_first_clk", bus.out_req_ready, 0);
    step();
    check("ready_after_first_clk", bus.out_req_ready, {NUM_REQ{1'b1}});

    // busy master: requests pending but no grant
    bus.in_ser_ready  = 1'b0;
    bus.in_req_enable = 2'b11;
    #1;
    check("busy_ready", bus.out_req_ready, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("busy_no_grant", bus.out_grant_valid, 0);
    end
    transaction(2'b01);
    transaction(2'b10);

    // contention: three grants each, alternating
    for (int t = 0; t < 6; t++) transaction(2'b11);

    // enable dropped during Grant
    bus.in_req_enable = 2'b10;
    g = rr_ref(2'b10, last);
    step();
    check("dg_grant", bus.out_grant, g);
    bus.in_req_enable = 2'b00;
    step();
    check("dg_no_enable", bus.out_ser_enable, 0);
    step();
    check("dg_release_enable", bus.out_ser_enable, 0);
    check("dg_release_valid", bus.out_grant_valid, 1);
    step();
    check("dg_idle", bus.out_grant_valid, 0);
    last = g;

    // hold timeout
    randomize_reqs();
    bus.in_req_enable = 2'b01;
    g = rr_ref(2'b01, last);
    step();
    check("to_grant", bus.out_grant, g);
    step();
    for (int c = 1; c < HOLD; c++) begin
      check("to_enable", bus.out_ser_enable, 1);
      check("to_no_error", bus.out_req_error, 0);
      step();
    end
    check("to_last_enable", bus.out_ser_enable, 1);
    check("to_error_pulse", bus.out_req_error, 1 << g);
    step();
    check("to_release_enable", bus.out_ser_enable, 0);
    check("to_release_error", bus.out_req_error, 0);
    check("to_release_valid", bus.out_grant_valid, 1);
    bus.in_req_enable = 2'b11;
    step();
    check("to_idle", bus.out_grant_valid, 0);
    last = g;
    g = rr_ref(2'b11, last);
    step();
    check("to_next_grant", bus.out_grant, g);
    check("to_next_valid", bus.out_grant_valid, 1);
    bus.in_req_enable = 2'b00;
    step();
    step();
    step();
    check("to_next_idle", bus.out_grant_valid, 0);
    last = g;

    // reset in the middle of an active transfer
    transaction(2'b11);
    bus.in_req_enable = 2'b01;
    bus.in_ser_ready  = 1'b1;
    step();
    step();
    check("mid_active", bus.out_ser_enable, 1);
    #2 in_rst = 1'b0;
    #1;
    check("mid_rst_enable", bus.out_ser_enable, 0);
    check("mid_rst_valid", bus.out_grant_valid, 0);
    check("mid_rst_grant", bus.out_grant, 0);
    check("mid_rst_ready", bus.out_req_ready, 0);
    bus.in_req_enable = 2'b00;
    #2 in_rst = 1'b1;
    last = NUM_REQ - 1;
    step();
    check("post_rst_ready", bus.out_req_ready, {NUM_REQ{1'b1}});
    transaction(2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
